// File: rtl/file_register_pkg.sv
`default_nettype none
// ============================================================================
// Module   : file_register_pkg
// Purpose  : Shared widths, one-hot controller states and $zero address.
// Revision : 1.0
// ============================================================================
package file_register_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int ADDR_W_DEF    = 5;
    localparam int ZERO_REG_ADDR = 0;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_WR   = 4'b0010,
        S_RD   = 4'b0100,
        S_RSP  = 4'b1000
    } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : regfile_bus_driver
// Purpose  : Per-bit tristate drivers placing write data on the shared bus.
// Revision : 1.0
// ============================================================================
module regfile_bus_driver #(
    parameter int DATA_W = 32
) (
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    inout  wire  [DATA_W-1:0] io_bus
);

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        bufif1 u_buf (io_bus[i], i_data[i], i_en);
    end

endmodule
`default_nettype wire

// File: rtl/file_register_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : file_register_ctrl
// Purpose  : Request sequencer for the 32x32 file register and its shared
//            data bus. Optional macro FILE_REGISTER_CTRL_ZERO_REG_EN gives
//            address 0 MIPS $zero semantics.
// Revision : 1.0
// ============================================================================
module file_register_ctrl
    import file_register_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_read0_addr,
    output logic [ADDR_W-1:0] rf_read1_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    inout  wire  [DATA_W-1:0] data_bus
);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_we;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                w_req_zero;
    logic                w_addr_zero;

`ifdef FILE_REGISTER_CTRL_ZERO_REG_EN
    assign w_req_zero  = (req_addr == ADDR_W'(ZERO_REG_ADDR));
    assign w_addr_zero = (r_addr == ADDR_W'(ZERO_REG_ADDR));
`else
    assign w_req_zero  = 1'b0;
    assign w_addr_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        if (!req_write) begin
                            r_state     <= S_RD;
                            r_req_ready <= 1'b0;
                        end else if (!w_req_zero) begin
                            r_state     <= S_WR;
                            r_req_ready <= 1'b0;
                            r_we        <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    r_state     <= S_IDLE;
                    r_we        <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                S_RD: begin
                    r_rsp_rdata <= w_addr_zero ? '0 : data_bus;
                    r_state     <= S_RSP;
                end
                S_RSP: begin
                    // Valid rises one cycle into RSP, giving the two-edge read latency.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_we        <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rf_we         = r_we;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rf_read0_addr = r_addr;
    assign rf_read1_addr = r_addr;
    assign rf_write_addr = r_addr;

    regfile_bus_driver #(
        .DATA_W (DATA_W)
    ) u_bus_driver (
        .i_en   (r_we),
        .i_data (r_wdata),
        .io_bus (data_bus)
    );

endmodule
`default_nettype wire

// File: tb/tb_file_register_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_file_register_ctrl
// Purpose  : Self-checking bench with a file register model on the shared bus.
// Revision : 1.0
// ============================================================================
module tb_file_register_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef FILE_REGISTER_CTRL_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_read0_addr;
    logic [ADDR_W-1:0] rf_read1_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    wire  [DATA_W-1:0] data_bus;

    logic [DATA_W-1:0] rf_mem  [32];
    logic [DATA_W-1:0] seed    [32];
    logic [DATA_W-1:0] ref_mem [32];
    logic              rf_load = 1'b0;
    int                n_vec = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    file_register_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rf_we         (rf_we),
        .rf_read0_addr (rf_read0_addr),
        .rf_read1_addr (rf_read1_addr),
        .rf_write_addr (rf_write_addr),
        .data_bus      (data_bus)
    );

    // File register: drives the bus whenever it is not being written.
    assign data_bus = rf_we ? {DATA_W{1'bz}} : rf_mem[rf_read1_addr];

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= seed[i];
        end else if (rf_we) begin
            rf_mem[rf_write_addr] <= data_bus;
        end
    end

    function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
        return (ZERO_EN && a == 0) ? '0 : ref_mem[a];
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (!(ZERO_EN && a == 0)) ref_mem[a] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0; req_wdata = $urandom;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d, output int lat);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin tick(); n++; end
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        d = rsp_rdata;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rf_load = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = seed[i];
        tick(); tick();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== '0) begin n_err++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        n_vec++; if (rf_write_addr !== '0 || rf_read0_addr !== '0 || rf_read1_addr !== '0) begin
            n_err++; $display("FAIL reset_addr got %h/%h/%h want 0", rf_write_addr, rf_read0_addr, rf_read1_addr);
        end
        rst = 1'b0; rf_load = 1'b0;
        tick();
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_write();
        do_write(5'd5, 32'hDEADBEEF);
        model_write(5'd5, 32'hDEADBEEF);
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL wr_we got %b want 1", rf_we); end
        n_vec++; if (rf_write_addr !== 5'd5) begin n_err++; $display("FAIL wr_addr got %0d want 5", rf_write_addr); end
        n_vec++; if (data_bus !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_bus got %h want deadbeef", data_bus); end
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL wr_ready got %b want 0", req_ready); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL wr_we_drop got %b want 0", rf_we); end
        n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_back got %b want 1", req_ready); end
        n_vec++; if (rf_write_addr !== 5'd5) begin n_err++; $display("FAIL wr_addr_hold got %0d want 5", rf_write_addr); end
    endtask

    task automatic test_read_after_write();
        logic [DATA_W-1:0] d;
        int lat;
        do_write(5'd5, 32'hDEADBEEF);
        model_write(5'd5, 32'hDEADBEEF);
        tick();
        do_read(5'd5, d, lat);
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL raw_latency got %0d want 2", lat); end
        n_vec++; if (d !== exp_read(5'd5)) begin n_err++; $display("FAIL raw_data got %h want %h", d, exp_read(5'd5)); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] pend;
        pend = $urandom;
        do_write(5'd7, 32'h12345678);
        model_write(5'd7, 32'h12345678);
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd7;
        tick();
        req_write = 1'b1; req_addr = 5'd12; req_wdata = pend;
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_rd got %b want 0", req_ready); end
        tick();
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_early got valid=%b ready=%b want 0/0", rsp_valid, req_ready);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_read(5'd7) || req_ready !== 1'b0 || rf_we !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b we=%b want 1/%h/0/0",
                                  i, rsp_valid, rsp_rdata, req_ready, rf_we, exp_read(5'd7));
            end
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL bp_release got valid=%b ready=%b we=%b want 0/1/0", rsp_valid, req_ready, rf_we);
        end
        tick();
        req_valid = 1'b0;
        model_write(5'd12, pend);
        n_vec++; if (rf_we !== 1'b1 || rf_write_addr !== 5'd12 || data_bus !== pend) begin
            n_err++; $display("FAIL bp_pending got we=%b addr=%0d bus=%h want 1/12/%h", rf_we, rf_write_addr, data_bus, pend);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic [DATA_W-1:0] d;
        int lat;
        int idx;
        idx = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd1; req_wdata = 32'h11;
        for (int c = 0; c < 6; c++) begin
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                idx++;
                model_write(ADDR_W'(idx), DATA_W'(idx * 32'h11));
                if (idx < 3) begin
                    req_addr = ADDR_W'(idx + 1); req_wdata = DATA_W'((idx + 1) * 32'h11);
                end else begin
                    req_valid = 1'b0;
                end
            end
            n_vec++; if (rf_we !== ((c % 2) == 0)) begin n_err++; $display("FAIL b2b_we[%0d] got %b want %b", c, rf_we, (c % 2) == 0); end
            if ((c % 2) == 0) begin
                n_vec++; if (rf_write_addr !== ADDR_W'(c / 2 + 1)) begin
                    n_err++; $display("FAIL b2b_addr[%0d] got %0d want %0d", c, rf_write_addr, c / 2 + 1);
                end
            end
        end
        req_valid = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            do_read(ADDR_W'(a), d, lat);
            n_vec++; if (d !== exp_read(ADDR_W'(a)) || lat != 2) begin
                n_err++; $display("FAIL b2b_readback[%0d] got %h lat %0d want %h lat 2", a, d, lat, exp_read(ADDR_W'(a)));
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [DATA_W-1:0] d;
        int lat;
        do_write(5'd9, 32'hA5A5A5A5);
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL rst_mid_setup got %b want 1", rf_we); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (rf_we !== 1'b0 || req_ready !== 1'b1 || rf_write_addr !== '0) begin
            n_err++; $display("FAIL rst_mid_abort got we=%b ready=%b addr=%0d want 0/1/0", rf_we, req_ready, rf_write_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        do_read(5'd9, d, lat);
        n_vec++; if (d !== exp_read(5'd9) || lat != 2) begin
            n_err++; $display("FAIL rst_mid_old got %h lat %0d want %h lat 2", d, lat, exp_read(5'd9));
        end
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd3;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rst_rsp_setup got %b want 1", rsp_valid); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b0 || rsp_rdata !== '0) begin
            n_err++; $display("FAIL rst_rsp_drop got valid=%b data=%h want 0/0", rsp_valid, rsp_rdata);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic exp_we;
        int lat;
        for (int k = 0; k < 40; k++) begin
            a = (k % 10 == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
            d = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                exp_we = !(ZERO_EN && a == 0);
                do_write(a, d);
                n_vec++; if (rf_we !== exp_we) begin n_err++; $display("FAIL rnd_we[%0d] got %b want %b", k, rf_we, exp_we); end
                if (exp_we) begin
                    n_vec++; if (data_bus !== d || rf_write_addr !== a) begin
                        n_err++; $display("FAIL rnd_wr[%0d] got bus=%h addr=%0d want %h/%0d", k, data_bus, rf_write_addr, d, a);
                    end
                end
                model_write(a, d);
                tick();
            end else begin
                do_read(a, d, lat);
                n_vec++; if (d !== exp_read(a) || lat != 2) begin
                    n_err++; $display("FAIL rnd_rd[%0d] addr %0d got %h lat %0d want %h lat 2", k, a, d, lat, exp_read(a));
                end
            end
        end
    endtask

`ifdef FILE_REGISTER_CTRL_ZERO_REG_EN
    task automatic test_zero_reg();
        logic [DATA_W-1:0] d;
        int lat;
        do_write(5'd0, 32'hFFFFFFFF);
        n_vec++; if (rf_we !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL zero_wr got we=%b ready=%b want 0/1", rf_we, req_ready);
        end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL zero_wr_late got %b want 0", rf_we); end
        do_read(5'd0, d, lat);
        n_vec++; if (d !== '0 || lat != 2) begin n_err++; $display("FAIL zero_rd got %h lat %0d want 0 lat 2", d, lat); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 32; i++) seed[i] = $urandom;
        test_reset();
        test_write();
        test_read_after_write();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
`ifdef FILE_REGISTER_CTRL_ZERO_REG_EN
        test_zero_reg();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

endmodule
`default_nettype wire
